dbg_mem_port: RTL and testbench
===============================

Name: dbg_mem_port

Overview:
- Debug responder that gives an external host access to CPU state without hierarchical testbench pokes.
- Accepts byte commands over a valid/ready stream and halts the CPU while it works.
- Reads and writes the data RAM and reads the register file through dedicated side ports.
- Returns read data, and full RAM dumps, over a valid/ready response stream. Sits beside cpu, between host link and ram0/rf0.

Parameters:
- DATA_W, 8, byte width of RAM, register file and streams.
- RAM_AW, 4, RAM address width (16 entries).
- RF_AW, 3, register file address width (8 entries).

Ports:
- clk  in  1  system clock.
- areset  in  1  synchronous active-high reset, sampled on posedge clk.
- cmd_valid  in  1  host command byte valid.
- cmd_ready  out  1  block accepts cmd_data this cycle.
- cmd_data  in  8  command or write-data byte.
- rsp_valid  out  1  response byte valid.
- rsp_ready  in  1  host accepts rsp_data.
- rsp_data  out  8  response byte.
- dbg_halt  out  1  CPU stall request; PC and regfile/RAM writes are frozen while high.
- mem_addr  out  4  RAM address.
- mem_we  out  1  RAM write strobe, one cycle.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data, valid 1 cycle after mem_addr is driven.
- rf_addr  out  3  regfile read address.
- rf_rdata  in  8  regfile read data, combinational from rf_addr.

Behaviour:
- Reset values: all outputs 0; state IDLE; cmd_ready=0 in reset cycle, 1 the cycle after.
- Handshake rule: a transfer occurs when valid&&ready at posedge.
- rsp_valid/rsp_data stay stable until rsp_ready is seen.
- Command byte format: op=cmd_data[7:6], arg=cmd_data[3:0].
  - 00 RD_RAM arg
  - 01 WR_RAM arg, followed by one data byte
  - 10 RD_REG arg[2:0]
  - 11 DUMP (arg ignored)
- dbg_halt rises the cycle after a command byte is accepted. It falls the cycle after the final response transfer; for WR_RAM it falls the cycle after mem_we.
- States:
  - IDLE: cmd_ready=1; on accept, latch op/arg → RD_RAM→MRD, WR_RAM→GETD, RD_REG→RSP (rsp_data=rf_rdata sampled that cycle), DUMP→MRD with index=0.
  - GETD: cmd_ready=1; on accept, drive mem_we=1, mem_addr=arg, mem_wdata=byte for exactly one cycle → IDLE. No response byte for writes.
  - MRD: drive mem_addr for one cycle, capture mem_rdata next cycle → RSP.
  - RSP: rsp_valid=1; on transfer, RD_* → IDLE; DUMP with index<15 → index+1, MRD; index==15 → IDLE, or → CSUM if feature enabled.
- Latency:
  - RD_RAM: rsp_valid 3 cycles after command accept.
  - RD_REG: rsp_valid 1 cycle after command accept.
  - DUMP: each byte 3 cycles after the previous transfer.
- cmd_ready=0 in MRD and RSP. Commands are never queued; back-to-back commands stall the host.
- Address wrap: the 4-bit index increments modulo 16; DUMP emits exactly 16 bytes, addresses 0..15.
- rsp_ready held high continuously gives full-rate streaming with no dropped bytes. rsp_ready low indefinitely holds state and keeps dbg_halt high.
- Reset mid-operation: the transaction is abandoned; all outputs return to reset values the next cycle. A pending WR_RAM is not written.
- cmd_valid with cmd_ready=0 has no effect.

Optional Feature:
- DBG_CHECKSUM_EN defined: after the 16th DUMP byte, state CSUM emits one extra byte, the 8-bit sum of the 16 bytes mod 256. dbg_halt drops after that transfer.
- Undefined: no CSUM state and no accumulator; DUMP ends after byte 15.

Test Plan:
- Reset: areset high 2 cycles → dbg_halt=0, rsp_valid=0, mem_we=0; cmd_ready=1 one cycle after release.
- Write then read: send 0x45, 0xA5 → single mem_we pulse with addr 5, data 0xA5. Send 0x05 → rsp_data=0xA5 three cycles after accept; dbg_halt high throughout each command.
- RD_REG: rf0 R3 preloaded 0x3C, send 0x83 → rsp_data=0x3C one cycle after accept.
- DUMP with backpressure: RAM[i]=i*3, rsp_ready toggling 1/0 → 16 bytes 0x00,0x03,…,0x2D in order, none duplicated or dropped. With DBG_CHECKSUM_EN, a 17th byte 0x68.
- Reset mid-DUMP: areset asserted after the 7th byte → rsp_valid=0 and dbg_halt=0 next cycle; a fresh 0x00 read succeeds.
- Stall: cmd_valid held with 0x02 during RSP of a previous read → accepted only after return to IDLE; response order preserved.

Source files
------------

// File: rtl/dbg_mem_port.sv
// Debug responder: host byte commands halt the CPU and read/write the data RAM,
// read the register file, or dump the whole RAM. Optional macro DBG_CHECKSUM_EN.
module dbg_mem_port #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RAM_AW = 4,
    parameter int unsigned RF_AW  = 3
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              dbg_halt,
    output logic [RAM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [RF_AW-1:0]  rf_addr,
    input  logic [DATA_W-1:0] rf_rdata
);

    localparam int unsigned OP_W = 2;
    localparam logic [OP_W-1:0]   OP_RD_RAM = 2'b00;
    localparam logic [OP_W-1:0]   OP_WR_RAM = 2'b01;
    localparam logic [OP_W-1:0]   OP_RD_REG = 2'b10;
    localparam logic [OP_W-1:0]   OP_DUMP   = 2'b11;
    localparam logic [RAM_AW-1:0] IDX_LAST  = '1;

`ifdef DBG_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_GETD, S_RREG, S_MRD, S_MWT, S_MCAP, S_RSP, S_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_GETD, S_RREG, S_MRD, S_MWT, S_MCAP, S_RSP
    } state_t;
`endif

    state_t            state, state_d;
    logic [OP_W-1:0]   op, op_d;
    logic [RAM_AW-1:0] idx, idx_d;
    logic              cmd_ready_d, rsp_valid_d, dbg_halt_d, mem_we_d;
    logic [DATA_W-1:0] rsp_data_d, mem_wdata_d;
    logic [RAM_AW-1:0] mem_addr_d;
    logic [RF_AW-1:0]  rf_addr_d;
`ifdef DBG_CHECKSUM_EN
    logic [DATA_W-1:0] sum, sum_d;
`endif

    logic [OP_W-1:0]   cmd_op;
    logic [RAM_AW-1:0] cmd_arg;
    logic              cmd_acc, rsp_xfer;
    logic              cmd_unused_bits;

    assign cmd_op          = cmd_data[DATA_W-1 -: OP_W];
    assign cmd_arg         = cmd_data[RAM_AW-1:0];
    assign cmd_unused_bits = ^cmd_data[DATA_W-OP_W-1:RAM_AW];
    assign cmd_acc         = cmd_valid && cmd_ready;
    assign rsp_xfer        = rsp_valid && rsp_ready;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (areset) begin
            state     <= S_IDLE;
            op        <= OP_RD_RAM;
            idx       <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            dbg_halt  <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rf_addr   <= '0;
`ifdef DBG_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            state     <= state_d;
            op        <= op_d;
            idx       <= idx_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            dbg_halt  <= dbg_halt_d;
            mem_addr  <= mem_addr_d;
            mem_we    <= mem_we_d;
            mem_wdata <= mem_wdata_d;
            rf_addr   <= rf_addr_d;
`ifdef DBG_CHECKSUM_EN
            sum       <= sum_d;
`endif
        end
    end

    // Next-state and next-output logic; RAM reads take MRD -> MWT -> MCAP
    always_comb begin
        state_d     = state;
        op_d        = op;
        idx_d       = idx;
        cmd_ready_d = cmd_ready;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        dbg_halt_d  = dbg_halt;
        mem_addr_d  = mem_addr;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata;
        rf_addr_d   = rf_addr;
`ifdef DBG_CHECKSUM_EN
        sum_d       = sum;
`endif
        case (state)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                dbg_halt_d  = 1'b0;
                if (cmd_acc) begin
                    op_d       = cmd_op;
                    idx_d      = (cmd_op == OP_DUMP) ? '0 : cmd_arg;
                    dbg_halt_d = 1'b1;
`ifdef DBG_CHECKSUM_EN
                    sum_d      = '0;
`endif
                    case (cmd_op)
                        OP_WR_RAM: state_d = S_GETD;
                        OP_RD_REG: begin
                            state_d     = S_RREG;
                            rf_addr_d   = cmd_data[RF_AW-1:0];
                            cmd_ready_d = 1'b0;
                        end
                        default: begin
                            state_d     = S_MRD;
                            cmd_ready_d = 1'b0;
                        end
                    endcase
                end
            end
            S_GETD: begin
                if (cmd_acc) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = idx;
                    mem_wdata_d = cmd_data;
                    state_d     = S_IDLE;
                end
            end
            S_RREG: begin
                rsp_data_d  = rf_rdata;
                rsp_valid_d = 1'b1;
                state_d     = S_RSP;
            end
            S_MRD: begin
                mem_addr_d = idx;
                state_d    = S_MWT;
            end
            S_MWT: state_d = S_MCAP;
            S_MCAP: begin
                rsp_data_d  = mem_rdata;
                rsp_valid_d = 1'b1;
`ifdef DBG_CHECKSUM_EN
                sum_d       = sum + mem_rdata;
`endif
                state_d     = S_RSP;
            end
            S_RSP: begin
                if (rsp_xfer) begin
                    rsp_valid_d = 1'b0;
                    if (op == OP_DUMP && idx != IDX_LAST) begin
                        idx_d   = idx + RAM_AW'(1);
                        state_d = S_MRD;
`ifdef DBG_CHECKSUM_EN
                    end else if (op == OP_DUMP) begin
                        rsp_data_d  = sum;
                        rsp_valid_d = 1'b1;
                        state_d     = S_CSUM;
`endif
                    end else begin
                        dbg_halt_d  = 1'b0;
                        cmd_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
`ifdef DBG_CHECKSUM_EN
            S_CSUM: begin
                if (rsp_xfer) begin
                    rsp_valid_d = 1'b0;
                    dbg_halt_d  = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dbg_mem_port.sv
// Self-checking bench for dbg_mem_port: directed vector table, multi-cycle corner
// sequences and randomized commands against a transaction-level memory model.
module tb_dbg_mem_port;

    logic       clk = 1'b0;
    logic       areset;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       dbg_halt;
    logic [3:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata, mem_rdata;
    logic [2:0] rf_addr;
    logic [7:0] rf_rdata;

    always #5 clk = ~clk;

    dbg_mem_port dut (
        .clk(clk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .dbg_halt(dbg_halt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata)
    );

    // Synchronous-read RAM and combinational register file beside the CPU
    logic [7:0] ram_mem [16];
    logic       ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= 8'(i * 3);
        end else if (mem_we) begin
            ram_mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram_mem[mem_addr];
    end

    function automatic logic [7:0] rf_val(input int i);
        return (i == 3) ? 8'h3C : 8'(8'h90 + i);
    endfunction

    logic [7:0] rf_mem [8];
    assign rf_rdata = rf_mem[rf_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int we_cnt = 0;
    always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;

    int checks = 0;
    int failures = 0;
    int acc_cyc, first_cyc, xfer_cyc;
    int exp_we = 0;
    logic [7:0] mdl_ram [16];

    typedef struct {
        logic       is_wr;
        logic [7:0] cmd;
        logic [7:0] wdata;
        logic [7:0] exp;
        int         lat;
    } vec_t;
    vec_t vecs [13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command byte and return just after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_data  = b;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        tick();
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    // Wait for a response byte, optionally stall it two cycles, then take it
    task automatic recv_byte(input bit bp, output logic [7:0] d);
        int n = 0;
        d = '0;
        rsp_ready = 1'b0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        if (!rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        first_cyc = cyc;
        chk("halt_during_rsp", dbg_halt, 1);
        d = rsp_data;
        if (bp) begin
            for (int k = 0; k < 2; k++) begin
                tick();
                chk("rsp_hold_valid", rsp_valid, 1);
                chk("rsp_hold_data", rsp_data, d);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        xfer_cyc  = cyc;
    endtask

    task automatic run_write(input logic [7:0] cmd, input logic [7:0] wdata);
        send_byte(cmd);
        chk("wr_halt_rise", dbg_halt, 1);
        send_byte(wdata);
        chk("wr_we_pulse", mem_we, 1);
        chk("wr_addr", mem_addr, cmd[3:0]);
        chk("wr_data", mem_wdata, wdata);
        chk("wr_halt_hold", dbg_halt, 1);
        tick();
        chk("wr_we_end", mem_we, 0);
        chk("wr_halt_fall", dbg_halt, 0);
        mdl_ram[cmd[3:0]] = wdata;
        exp_we++;
    endtask

    task automatic run_read(input logic [7:0] cmd, input bit bp,
                            input logic [7:0] exp, input int lat);
        logic [7:0] d;
        send_byte(cmd);
        chk("rd_halt_rise", dbg_halt, 1);
        recv_byte(bp, d);
        chk("rd_data", d, exp);
        chk("rd_latency", first_cyc - acc_cyc, lat);
        chk("rd_halt_fall", dbg_halt, 0);
    endtask

    // mode 0: ready always taken, 1: alternate stalls, 2: random stalls
    task automatic run_dump(input int mode, input int stop_after);
        logic [7:0] d;
        logic [7:0] sum;
        int prev;
        bit bp;
        sum = '0;
        send_byte(8'hC0 | 8'($urandom_range(0, 63)));
        chk("dump_halt_rise", dbg_halt, 1);
        prev = acc_cyc;
        for (int i = 0; i < 16; i++) begin
            bp = (mode == 1) ? i[0] : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            recv_byte(bp, d);
            chk("dump_byte", d, mdl_ram[i]);
            chk("dump_gap", first_cyc - prev, 3);
            prev = xfer_cyc;
            sum  = sum + d;
            if (i + 1 == stop_after) return;
        end
`ifdef DBG_CHECKSUM_EN
        recv_byte(mode != 0, d);
        chk("dump_csum", d, sum);
`endif
        chk("dump_halt_fall", dbg_halt, 0);
        for (int k = 0; k < 4; k++) tick();
        chk("dump_no_extra", rsp_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] d1, d2;
        areset    = 1'b1;
        ram_init  = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) rf_mem[i] = rf_val(i);
        for (int i = 0; i < 16; i++) mdl_ram[i] = 8'(i * 3);

        vecs[0]  = '{1'b1, 8'h45, 8'hA5, 8'h00, 0};
        vecs[1]  = '{1'b0, 8'h05, 8'h00, 8'hA5, 3};
        vecs[2]  = '{1'b0, 8'h83, 8'h00, 8'h3C, 1};
        vecs[3]  = '{1'b0, 8'h0F, 8'h00, 8'h2D, 3};
        vecs[4]  = '{1'b0, 8'h00, 8'h00, 8'h00, 3};
        vecs[5]  = '{1'b1, 8'h4F, 8'h5A, 8'h00, 0};
        vecs[6]  = '{1'b0, 8'h0F, 8'h00, 8'h5A, 3};
        vecs[7]  = '{1'b0, 8'h87, 8'h00, 8'h97, 1};
        vecs[8]  = '{1'b0, 8'h8B, 8'h00, 8'h3C, 1};
        vecs[9]  = '{1'b0, 8'hB5, 8'h00, 8'h95, 1};
        vecs[10] = '{1'b0, 8'h35, 8'h00, 8'hA5, 3};
        vecs[11] = '{1'b1, 8'h7A, 8'hFF, 8'h00, 0};
        vecs[12] = '{1'b0, 8'h0A, 8'h00, 8'hFF, 3};

        // Reset held two cycles
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_halt", dbg_halt, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_cmd_ready", cmd_ready, 0);
        end
        areset   = 1'b0;
        ram_init = 1'b0;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Full dump with alternating backpressure, then reset part-way through one
        run_dump(1, 16);
        run_dump(0, 7);
        areset = 1'b1;
        tick();
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_halt", dbg_halt, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        areset = 1'b0;
        run_read(8'h00, 1'b0, mdl_ram[0], 3);

        // Directed vector table
        for (int v = 0; v < 13; v++) begin
            if (vecs[v].is_wr) run_write(vecs[v].cmd, vecs[v].wdata);
            else               run_read(vecs[v].cmd, 1'b0, vecs[v].exp, vecs[v].lat);
        end

        // Command held while a previous read is outstanding
        send_byte(8'h01);
        cmd_valid = 1'b1;
        cmd_data  = 8'h02;
        recv_byte(1'b1, d1);
        chk("stall_cmd_ready_after_xfer", cmd_ready, 1);
        chk("stall_halt_dropped", dbg_halt, 0);
        tick();
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        chk("stall_accept_halt", dbg_halt, 1);
        recv_byte(1'b0, d2);
        chk("stall_first_data", d1, mdl_ram[1]);
        chk("stall_second_data", d2, mdl_ram[2]);
        chk("stall_second_latency", first_cyc - acc_cyc, 3);

        // Randomized commands against the model
        for (int t = 0; t < 30; t++) begin
            int         op;
            logic [3:0] arg;
            logic [7:0] cmd;
            op  = int'($urandom_range(0, 3));
            arg = 4'($urandom_range(0, 15));
            cmd = {2'(op), 2'($urandom_range(0, 3)), arg};
            case (op)
                0: run_read(cmd, 1'($urandom_range(0, 1)), mdl_ram[arg], 3);
                1: run_write(cmd, 8'($urandom_range(0, 255)));
                2: run_read(cmd, 1'($urandom_range(0, 1)), rf_val(int'(arg[2:0])), 1);
                default: run_dump(2, 16);
            endcase
        end

        tick();
        chk("write_pulse_count", we_cnt, exp_we);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
